// File: rtl/vga_pkg.sv
// Shared timing defaults, scan state encoding and small constant helpers
// for the VGA raster engine.
package vga_pkg;

    localparam int DEF_H_ACT  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_V_ACT  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;

    typedef enum logic [1:0] {IDLE, RUN, STOP} scanState_t;

    function automatic int totalOf(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int ceilLog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register pipe used to realign sync/blank/cursor flags with
// the pixel data returning from the frame buffer. DEPTH=0 is a wire.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic [WIDTH-1:0] iD,
    output logic [WIDTH-1:0] oQ
);

    generate
        if (DEPTH == 0) begin : gPass
            assign oQ = iD;
        end else begin : gPipe
            logic [DEPTH-1:0][WIDTH-1:0] pipe;

            always_ff @(posedge iCLK or negedge iRST_N) begin
                if (!iRST_N) begin
                    pipe <= '0;
                end else begin
                    pipe[0] <= iD;
                    for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
                end
            end

            assign oQ = pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_scan_controller.sv
// VGA raster engine: scan counters, pixel request stream with linear
// address, sync/blank generation aligned to fetched data, crosshair overlay.
module vga_scan_controller
    import vga_pkg::*;
#(
    parameter int COLOR_W  = 10,
    parameter int H_ACT    = DEF_H_ACT,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACT    = DEF_V_ACT,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int RD_LAT   = 2,
    parameter int CUR_HALF = 1,
    localparam int ADDR_W  = ceilLog2(H_ACT * V_ACT)
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iEnable,
    input  logic               iCursor_EN,
    input  logic [11:0]        iCursor_X,
    input  logic [11:0]        iCursor_Y,
    input  logic [COLOR_W-1:0] iCursor_R,
    input  logic [COLOR_W-1:0] iCursor_G,
    input  logic [COLOR_W-1:0] iCursor_B,
    input  logic [COLOR_W-1:0] iRed,
    input  logic [COLOR_W-1:0] iGreen,
    input  logic [COLOR_W-1:0] iBlue,
    output logic               oReq,
    output logic [ADDR_W-1:0]  oAddress,
    output logic [11:0]        oCoord_X,
    output logic [11:0]        oCoord_Y,
    output logic [COLOR_W-1:0] oVGA_R,
    output logic [COLOR_W-1:0] oVGA_G,
    output logic [COLOR_W-1:0] oVGA_B,
    output logic               oVGA_H_SYNC,
    output logic               oVGA_V_SYNC,
    output logic               oVGA_BLANK_N,
    output logic               oVGA_SYNC,
    output logic               oVGA_CLOCK,
    output logic               oFrame_Start,
    output logic               oLine_Start
);

    localparam int H_TOT = totalOf(H_ACT, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = totalOf(V_ACT, V_FP, V_SYNC, V_BP);
    localparam logic [11:0] H_ACT12 = 12'(H_ACT);
    localparam logic [11:0] V_ACT12 = 12'(V_ACT);
    localparam logic [11:0] H_LAST  = 12'(H_TOT - 1);
    localparam logic [11:0] V_LAST  = 12'(V_TOT - 1);
    localparam logic [11:0] HS_BEG  = 12'(H_ACT + H_FP);
    localparam logic [11:0] HS_END  = 12'(H_ACT + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEG  = 12'(V_ACT + V_FP);
    localparam logic [11:0] VS_END  = 12'(V_ACT + V_FP + V_SYNC);
    localparam logic [11:0] HALF12  = 12'(CUR_HALF);
    localparam logic        HS_ON   = 1'(HS_POL);
    localparam logic        VS_ON   = 1'(VS_POL);

    scanState_t state;
    logic [11:0] h, v;
    logic [ADDR_W-1:0] addrCnt;
    logic curEn;
    logic [11:0] curX, curY;
    logic [COLOR_W-1:0] curR, curG, curB;
    logic lastH, lastPos, running, active, hsAct, vsAct, hit;
    logic hsR, vsR, hitR, hsD, vsD, actD, hitD;

    // Distance taken in the unsigned domain so there is no wrap-around hit.
    function automatic logic axisHit(input logic [11:0] p, input logic [11:0] c,
                                     input logic [11:0] act);
        logic [11:0] d;
        d = (p >= c) ? p - c : c - p;
        return (c < act) && (d <= HALF12);
    endfunction

    assign lastH   = (h == H_LAST);
    assign lastPos = lastH && (v == V_LAST);
    assign running = (state != IDLE);
    assign active  = running && (h < H_ACT12) && (v < V_ACT12);
    assign hsAct   = running && (h >= HS_BEG) && (h < HS_END);
    assign vsAct   = running && (v >= VS_BEG) && (v < VS_END);
    assign hit     = curEn && (axisHit(h, curX, H_ACT12) || axisHit(v, curY, V_ACT12));

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state <= IDLE;
            h     <= '0;
            v     <= '0;
            curEn <= 1'b0;
            curX  <= '0;
            curY  <= '0;
            curR  <= '0;
            curG  <= '0;
            curB  <= '0;
        end else begin
            // Cursor only moves between frames so the overlay never tears.
            if (state == IDLE || lastPos) begin
                curEn <= iCursor_EN;
                curX  <= iCursor_X;
                curY  <= iCursor_Y;
                curR  <= iCursor_R;
                curG  <= iCursor_G;
                curB  <= iCursor_B;
            end
            if (state == IDLE) begin
                h <= '0;
                v <= '0;
                if (iEnable) state <= RUN;
            end else begin
                h <= lastH ? '0 : h + 1'b1;
                if (lastH) v <= lastPos ? '0 : v + 1'b1;
                if (iEnable)                       state <= RUN;
                else if (state == RUN && !lastPos) state <= STOP;
                else if (lastPos)                  state <= IDLE;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oReq         <= 1'b0;
            oFrame_Start <= 1'b0;
            oLine_Start  <= 1'b0;
            oCoord_X     <= '0;
            oCoord_Y     <= '0;
            oAddress     <= '0;
            addrCnt      <= '0;
            hsR          <= 1'b0;
            vsR          <= 1'b0;
            hitR         <= 1'b0;
        end else begin
            oReq         <= active;
            oLine_Start  <= active && (h == '0);
            oFrame_Start <= active && (h == '0) && (v == '0);
            oCoord_X     <= h;
            oCoord_Y     <= v;
            hsR          <= hsAct;
            vsR          <= vsAct;
            hitR         <= active && hit;
            if (!running) begin
                oAddress <= '0;
                addrCnt  <= '0;
            end else if (active) begin
                if (h == '0 && v == '0) begin
                    oAddress <= '0;
                    addrCnt  <= ADDR_W'(1);
                end else begin
                    oAddress <= addrCnt;
                    addrCnt  <= addrCnt + 1'b1;
                end
            end
        end
    end

    vga_delay_line #(.WIDTH(4), .DEPTH(RD_LAT)) uDelay (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .iD     ({hsR, vsR, oReq, hitR}),
        .oQ     ({hsD, vsD, actD, hitD})
    );

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oVGA_R       <= '0;
            oVGA_G       <= '0;
            oVGA_B       <= '0;
            oVGA_BLANK_N <= 1'b0;
            oVGA_H_SYNC  <= ~HS_ON;
            oVGA_V_SYNC  <= ~VS_ON;
        end else begin
            oVGA_BLANK_N <= actD;
            oVGA_H_SYNC  <= hsD ? HS_ON : ~HS_ON;
            oVGA_V_SYNC  <= vsD ? VS_ON : ~VS_ON;
            oVGA_R       <= !actD ? '0 : (hitD ? curR : iRed);
            oVGA_G       <= !actD ? '0 : (hitD ? curG : iGreen);
            oVGA_B       <= !actD ? '0 : (hitD ? curB : iBlue);
        end
    end

    assign oVGA_SYNC  = 1'b0;
    assign oVGA_CLOCK = iCLK;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Scoreboard bench for vga_scan_controller on a tiny 8x4 raster; two
// instances differ only in cursor half-thickness (0 and 1).
module tb_vga_scan_controller;

    localparam int CW = 10;
    localparam int HA = 8, HF = 2, HSW = 3, HB = 2;
    localparam int VA = 4, VF = 1, VSW = 2, VB = 1;
    localparam int LAT = 2;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FRAME = HT * VT;
    localparam int DLY = LAT + 1;

    typedef struct {
        longint cyc;
        bit req, fs, ls;
        int x, y, addr;
    } reqExp_t;

    typedef struct {
        longint cyc;
        bit hs, vs, blank;
        int r0, g0, b0, r1, g1, b1;
    } dacExp_t;

    logic iCLK = 1'b0, iRST_N = 1'b1, iEnable = 1'b0, iCursor_EN = 1'b0;
    logic [11:0] iCursor_X = '0, iCursor_Y = '0;
    logic [CW-1:0] iCursor_R = '0, iCursor_G = '0, iCursor_B = '0;
    logic [CW-1:0] iRed = '0, iGreen = '0, iBlue = '0;

    logic oReq, oVGA_H_SYNC, oVGA_V_SYNC, oVGA_BLANK_N, oVGA_SYNC, oVGA_CLOCK, oFrame_Start, oLine_Start;
    logic [4:0] oAddress;
    logic [11:0] oCoord_X, oCoord_Y;
    logic [CW-1:0] oVGA_R, oVGA_G, oVGA_B;

    logic oReq1, oHs1, oVs1, oBlank1, oSync1, oClk1, oFs1, oLs1;
    logic [4:0] oAddress1;
    logic [11:0] oX1, oY1;
    logic [CW-1:0] oR1, oG1, oB1;

    vga_scan_controller #(
        .COLOR_W(CW), .H_ACT(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACT(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(0), .VS_POL(0), .RD_LAT(LAT), .CUR_HALF(0)
    ) dut0 (
        .iCLK(iCLK), .iRST_N(iRST_N), .iEnable(iEnable), .iCursor_EN(iCursor_EN),
        .iCursor_X(iCursor_X), .iCursor_Y(iCursor_Y),
        .iCursor_R(iCursor_R), .iCursor_G(iCursor_G), .iCursor_B(iCursor_B),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .oReq(oReq), .oAddress(oAddress), .oCoord_X(oCoord_X), .oCoord_Y(oCoord_Y),
        .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
        .oVGA_H_SYNC(oVGA_H_SYNC), .oVGA_V_SYNC(oVGA_V_SYNC), .oVGA_BLANK_N(oVGA_BLANK_N),
        .oVGA_SYNC(oVGA_SYNC), .oVGA_CLOCK(oVGA_CLOCK),
        .oFrame_Start(oFrame_Start), .oLine_Start(oLine_Start)
    );

    vga_scan_controller #(
        .COLOR_W(CW), .H_ACT(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACT(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(0), .VS_POL(0), .RD_LAT(LAT), .CUR_HALF(1)
    ) dut1 (
        .iCLK(iCLK), .iRST_N(iRST_N), .iEnable(iEnable), .iCursor_EN(iCursor_EN),
        .iCursor_X(iCursor_X), .iCursor_Y(iCursor_Y),
        .iCursor_R(iCursor_R), .iCursor_G(iCursor_G), .iCursor_B(iCursor_B),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .oReq(oReq1), .oAddress(oAddress1), .oCoord_X(oX1), .oCoord_Y(oY1),
        .oVGA_R(oR1), .oVGA_G(oG1), .oVGA_B(oB1),
        .oVGA_H_SYNC(oHs1), .oVGA_V_SYNC(oVs1), .oVGA_BLANK_N(oBlank1),
        .oVGA_SYNC(oSync1), .oVGA_CLOCK(oClk1),
        .oFrame_Start(oFs1), .oLine_Start(oLs1)
    );

    always #5 iCLK = ~iCLK;

    longint cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    int nChecks = 0, nFail = 0;
    int saltR = 0, saltG = 0, saltB = 0;
    reqExp_t reqQ[$];
    dacExp_t dacQ[$];

    task automatic chk(input string name, input int got, input int exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", name, cyc, got, exp);
        end
    endtask

    function automatic int srcR(input int a); return (a + saltR) & 1023; endfunction
    function automatic int srcG(input int a); return (a * 5 + saltG) & 1023; endfunction
    function automatic int srcB(input int a); return (saltB - a) & 1023; endfunction

    function automatic bit axisHit(input int p, input int c, input int act, input int half);
        int d;
        d = (p > c) ? p - c : c - p;
        return (c < act) && (d <= half);
    endfunction

    // Reference raster: request for position p appears at s+p, its DAC pixel DLY later.
    task automatic pushFrame(input longint s, input bit ce, input int cx, input int cy,
                             input int cr, input int cg, input int cb);
        for (int p = 0; p < FRAME; p++) begin
            reqExp_t rq;
            dacExp_t dq;
            int h, v, a;
            bit act, hit0, hit1;
            h = p % HT;
            v = p / HT;
            act = (h < HA) && (v < VA);
            a = v * HA + h;
            rq.cyc = s + p; rq.req = act; rq.x = h; rq.y = v; rq.addr = a;
            rq.fs = act && h == 0 && v == 0; rq.ls = act && h == 0;
            reqQ.push_back(rq);
            hit0 = ce && (axisHit(h, cx, HA, 0) || axisHit(v, cy, VA, 0));
            hit1 = ce && (axisHit(h, cx, HA, 1) || axisHit(v, cy, VA, 1));
            dq.cyc = s + p + DLY;
            dq.hs = !(h >= HA + HF && h < HA + HF + HSW);
            dq.vs = !(v >= VA + VF && v < VA + VF + VSW);
            dq.blank = act;
            dq.r0 = !act ? 0 : hit0 ? cr : srcR(a);
            dq.g0 = !act ? 0 : hit0 ? cg : srcG(a);
            dq.b0 = !act ? 0 : hit0 ? cb : srcB(a);
            dq.r1 = !act ? 0 : hit1 ? cr : srcR(a);
            dq.g1 = !act ? 0 : hit1 ? cg : srcG(a);
            dq.b1 = !act ? 0 : hit1 ? cb : srcB(a);
            dacQ.push_back(dq);
        end
    endtask

    task automatic pushIdle(input longint s, input int n);
        for (int i = 0; i < n; i++) begin
            reqExp_t rq;
            dacExp_t dq;
            rq.cyc = s + i; rq.req = 0; rq.x = 0; rq.y = 0; rq.addr = 0; rq.fs = 0; rq.ls = 0;
            reqQ.push_back(rq);
            dq.cyc = s + i + DLY; dq.hs = 1; dq.vs = 1; dq.blank = 0;
            dq.r0 = 0; dq.g0 = 0; dq.b0 = 0; dq.r1 = 0; dq.g1 = 0; dq.b1 = 0;
            dacQ.push_back(dq);
        end
    endtask

    task automatic checkResetValues(input string tag);
        chk({tag, "_req"}, oReq, 0);
        chk({tag, "_addr"}, oAddress, 0);
        chk({tag, "_x"}, oCoord_X, 0);
        chk({tag, "_y"}, oCoord_Y, 0);
        chk({tag, "_r"}, oVGA_R, 0);
        chk({tag, "_g"}, oVGA_G, 0);
        chk({tag, "_b"}, oVGA_B, 0);
        chk({tag, "_blank_n"}, oVGA_BLANK_N, 0);
        chk({tag, "_hsync"}, oVGA_H_SYNC, 1);
        chk({tag, "_vsync"}, oVGA_V_SYNC, 1);
        chk({tag, "_fs"}, oFrame_Start, 0);
        chk({tag, "_ls"}, oLine_Start, 0);
        chk({tag, "_vga_sync"}, oVGA_SYNC, 0);
        chk({tag, "_r1"}, oR1, 0);
    endtask

    task automatic waitUntil(input longint c);
        while (cyc < c) @(negedge iCLK);
    endtask

    // Frame buffer model: returns data LAT clocks after each request.
    int histA[LAT+1];
    bit histV[LAT+1];
    always @(negedge iCLK) begin
        for (int k = LAT; k > 0; k--) begin
            histA[k] = histA[k-1];
            histV[k] = histV[k-1];
        end
        histA[0] = oAddress;
        histV[0] = oReq;
        if (histV[LAT]) begin
            iRed   = CW'(srcR(histA[LAT]));
            iGreen = CW'(srcG(histA[LAT]));
            iBlue  = CW'(srcB(histA[LAT]));
        end else begin
            iRed   = CW'($urandom);
            iGreen = CW'($urandom);
            iBlue  = CW'($urandom);
        end
    end

    always @(negedge iCLK) begin
        reqExp_t rq;
        dacExp_t dq;
        while (reqQ.size() > 0 && reqQ[0].cyc < cyc) begin
            nChecks++; nFail++;
            $display("FAIL req_stale @cyc %0d: record for cyc %0d never compared", cyc, reqQ[0].cyc);
            void'(reqQ.pop_front());
        end
        while (dacQ.size() > 0 && dacQ[0].cyc < cyc) begin
            nChecks++; nFail++;
            $display("FAIL dac_stale @cyc %0d: record for cyc %0d never compared", cyc, dacQ[0].cyc);
            void'(dacQ.pop_front());
        end
        if (reqQ.size() > 0 && reqQ[0].cyc == cyc) begin
            rq = reqQ.pop_front();
            chk("req", oReq, rq.req);
            chk("frame_start", oFrame_Start, rq.fs);
            chk("line_start", oLine_Start, rq.ls);
            if (rq.req) begin
                chk("coord_x", oCoord_X, rq.x);
                chk("coord_y", oCoord_Y, rq.y);
                chk("address", oAddress, rq.addr);
            end
        end
        if (dacQ.size() > 0 && dacQ[0].cyc == cyc) begin
            dq = dacQ.pop_front();
            chk("hsync", oVGA_H_SYNC, dq.hs);
            chk("vsync", oVGA_V_SYNC, dq.vs);
            chk("blank_n", oVGA_BLANK_N, dq.blank);
            chk("dac_r", oVGA_R, dq.r0);
            chk("dac_g", oVGA_G, dq.g0);
            chk("dac_b", oVGA_B, dq.b0);
            chk("blank_n_h1", oBlank1, dq.blank);
            chk("dac_r_h1", oR1, dq.r1);
            chk("dac_g_h1", oG1, dq.g1);
            chk("dac_b_h1", oB1, dq.b1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        longint s;
        int c2r, c2g, c2b, bx, by, br, bg, bb;
        #1 iRST_N = 1'b0;
        #2 checkResetValues("por");
        repeat (3) @(negedge iCLK);
        iRST_N = 1'b1;
        repeat (2) @(negedge iCLK);

        // Three back-to-back frames: no cursor, crosshair (3,2), edge cursor at X=0.
        saltR = 0;
        saltG = int'($urandom_range(0, 1023));
        saltB = int'($urandom_range(0, 1023));
        c2r = int'($urandom_range(0, 1023));
        c2g = int'($urandom_range(0, 1023));
        c2b = int'($urandom_range(0, 1023));
        s = cyc + 2;
        iEnable = 1'b1;
        pushFrame(s, 0, 0, 0, 0, 0, 0);
        pushFrame(s + FRAME, 1, 3, 2, 'h3FF, 'h3FF, 'h3FF);
        pushFrame(s + 2 * FRAME, 1, 0, 5, c2r, c2g, c2b);
        pushIdle(s + 3 * FRAME, 20);
        waitUntil(s + 50);
        iCursor_EN = 1'b1; iCursor_X = 12'd3; iCursor_Y = 12'd2;
        iCursor_R = 10'h3FF; iCursor_G = 10'h3FF; iCursor_B = 10'h3FF;
        waitUntil(s + FRAME + HT);
        iEnable = 1'b0;
        iCursor_X = 12'd0; iCursor_Y = 12'd5;
        iCursor_R = CW'(c2r); iCursor_G = CW'(c2g); iCursor_B = CW'(c2b);
        waitUntil(s + 2 * FRAME - 2);
        iEnable = 1'b1;
        waitUntil(s + 2 * FRAME + HT);
        iEnable = 1'b0;
        waitUntil(s + 3 * FRAME + 20 + DLY + 2);

        // Random cursor/data, then an asynchronous reset in the middle of line 0.
        saltR = int'($urandom_range(0, 1023));
        saltG = int'($urandom_range(0, 1023));
        saltB = int'($urandom_range(0, 1023));
        bx = int'($urandom_range(0, 9));
        by = int'($urandom_range(0, 5));
        br = int'($urandom_range(0, 1023));
        bg = int'($urandom_range(0, 1023));
        bb = int'($urandom_range(0, 1023));
        iCursor_EN = 1'b1; iCursor_X = 12'(bx); iCursor_Y = 12'(by);
        iCursor_R = CW'(br); iCursor_G = CW'(bg); iCursor_B = CW'(bb);
        s = cyc + 2;
        iEnable = 1'b1;
        pushFrame(s, 1, bx, by, br, bg, bb);
        waitUntil(s + 4);
        #2 iRST_N = 1'b0;
        #1 checkResetValues("mid_line");
        reqQ.delete();
        dacQ.delete();
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
        s = cyc + 2;
        pushFrame(s, 1, bx, by, br, bg, bb);
        pushIdle(s + FRAME, 20);
        waitUntil(s + HT);
        iEnable = 1'b0;
        waitUntil(s + FRAME + 20 + DLY + 2);

        chk("req_queue_drained", reqQ.size(), 0);
        chk("dac_queue_drained", dacQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/vga_scan_controller.md
Name: vga_scan_controller

Overview:
Parametrised VGA raster engine for the DE2 display path. It generates H/V sync and blank from configurable timing, and issues a pixel-request stream with linear frame-buffer address and coordinates. It realigns returned pixel data of fixed latency RD_LAT with sync/blank, and overlays a configurable crosshair cursor. It sits between the frame-buffer/pattern source and the ADV7123 DAC pins.

Parameters:
COLOR_W, 10, bits per colour channel
H_ACT, 640, active pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACT, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
HS_POL, 0, active level of oVGA_H_SYNC
VS_POL, 0, active level of oVGA_V_SYNC
RD_LAT, 2, clocks from oReq to valid iRed/iGreen/iBlue (0..7)
CUR_HALF, 1, cursor arm half-thickness; arm width = 2*CUR_HALF+1

Ports:
iCLK in 1 pixel clock
iRST_N in 1 asynchronous active-low reset
iEnable in 1 run request, sampled at frame boundary
iCursor_EN in 1 cursor overlay enable
iCursor_X in 12 cursor column
iCursor_Y in 12 cursor row
iCursor_R/G/B in COLOR_W each, cursor colour
iRed/iGreen/iBlue in COLOR_W each, pixel data, valid RD_LAT clocks after oReq
oReq out 1 pixel fetch strobe
oAddress out ADDR_W linear address, ADDR_W = clog2(H_ACT*V_ACT)
oCoord_X out 12 active column of current request
oCoord_Y out 12 active row of current request
oVGA_R/G/B out COLOR_W each, DAC colour
oVGA_H_SYNC out 1
oVGA_V_SYNC out 1
oVGA_BLANK_N out 1 high during visible pixels
oVGA_SYNC out 1 constant 0
oVGA_CLOCK out 1 = iCLK
oFrame_Start out 1 one-clock pulse on first request of a frame
oLine_Start out 1 one-clock pulse on first request of each active line

Behaviour:
- Reset is decided: reset iRST_N, asynchronous, active-low; clock iCLK.
- Reset values: counters 0, state IDLE, oReq/oFrame_Start/oLine_Start 0, oAddress/oCoord 0, RGB 0, BLANK_N 0, syncs at inactive level (~HS_POL, ~VS_POL).
- Line layout: h = 0..H_ACT-1 active, then FP, SYNC, BP; H_TOT = sum; h wraps H_TOT-1 -> 0 and increments v. Frame layout is the same in v; V_TOT = sum; v wraps to 0.
- FSM: IDLE -> RUN when iEnable=1 (counters start at h=v=0 next clock). RUN -> STOP when iEnable=0 mid-frame. STOP completes the frame and goes to IDLE at the last h/v of the frame, unless iEnable=1 again, in which case it continues in RUN seamlessly. In IDLE, counters are held at 0 and outputs are idle (reset values).
- Request stage (registered, cycle 0): oReq=1 iff RUN/STOP and h<H_ACT and v<V_ACT. oCoord_X=h, oCoord_Y=v. oAddress cleared at frame start and incremented after every request, so it equals Y*H_ACT+X with no multiplier. oLine_Start with h=0 active; oFrame_Start with h=0,v=0.
- Alignment: sync, blank, active flag and cursor hit are delayed by a shift register of depth RD_LAT. Output registers add 1 clock. DAC pixel for a request appears RD_LAT+1 clocks after its oReq. Sync pulses keep the same relative offset to their pixels as the raw counters.
- Sync: active when h in [H_ACT+H_FP, H_ACT+H_FP+H_SYNC-1] (H) or the equivalent line range (V), driven at the POL level. V sync changes only at h=0.
- Cursor hit: |X-iCursor_X|<=CUR_HALF or |Y-iCursor_Y|<=CUR_HALF, with iCursor_EN=1, evaluated on request coordinates. Use unsigned compare without wrap, so a cursor at 0 does not hit H_ACT-1. Cursor inputs are sampled at frame start only, giving tear-free movement.
- Output colour: blanked -> 0; hit -> cursor colour; otherwise iRed/iGreen/iBlue.
- Cursor coordinates outside the active area produce no hit on that axis.

Decomposition:
- Package vga_pkg: default 640x480@60 timing constants, a function computing H_TOT/V_TOT, and a clog2 helper for ADDR_W.
- Sub-module vga_delay_line (param WIDTH, DEPTH; DEPTH=0 passes through) used for sync/blank/hit alignment.

Test Plan:
Test parameters: H_ACT=8, H_FP=2, H_SYNC=3, H_BP=2, V_ACT=4, V_FP=1, V_SYNC=2, V_BP=1, RD_LAT=2, CUR_HALF=0.
- Timing: iEnable=1 after reset -> HS low for 3 clocks starting 10 clocks after first oReq (plus 3 on the DAC side), line period 15, frame period 120, 32 oReq per frame.
- Address: model returns data=address -> oVGA_R sequence 0..31 appears exactly 3 clocks after matching oReq, with BLANK_N=1 only on those clocks.
- Cursor: cursor enabled at X=3, Y=2, colour 0x3FF -> column 3 on all rows and all of row 2 output 0x3FF; other pixels keep source data.
- Cursor edge: cursor at X=0 with CUR_HALF=1 -> columns 0,1 hit, column 7 not hit.
- Enable: drop iEnable at v=1 -> frame completes (32 requests), then IDLE with syncs inactive. Reassert at the last clock of the frame -> no gap, next frame starts at h=v=0.
- Reset mid-line: pulse iRST_N low at h=5 -> all outputs at reset values immediately (asynchronous); restart from h=v=0.
